// File: rtl/data_path_pkg.sv
// Shared constants and FSM state encoding for the shift-and-add multiplier.
package data_path_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/data_path_if.sv
// Operand/result bundle between the operand source, the multiplier and the result consumer.
interface data_path_if
    import data_path_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0]   Data_A;
    logic [WIDTH-1:0]   Data_B;
    logic               iValid_Data;
    logic               iAck;
    logic [2*WIDTH-1:0] Prod;
    logic               oDone;
    logic               oBusy;
    logic               oB_LSB;

    modport master (
        output Data_A, Data_B, iValid_Data, iAck,
        input  Prod, oDone, oBusy, oB_LSB
    );

    modport slave (
        input  Data_A, Data_B, iValid_Data, iAck,
        output Prod, oDone, oBusy, oB_LSB
    );
endinterface

// File: rtl/data_path_control_machine.sv
// Sequencing FSM for the multiplier: IDLE -> RUN (WIDTH iterations) -> DONE -> IDLE on ack.
module control_machine
    import data_path_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic iValid_Data,
    input  logic iAck,
    input  logic iLSB,
    input  logic count_done,
    output logic a_sel,
    output logic b_sel,
    output logic prod_sel,
    output logic add_sel,
    output logic shift_en,
    output logic oDone,
    output logic oBusy
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sel    = 1'b0;
        b_sel    = 1'b0;
        prod_sel = 1'b0;
        add_sel  = 1'b0;
        shift_en = 1'b0;
        oDone    = 1'b0;
        oBusy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (iValid_Data) begin
                    a_sel    = 1'b1;
                    b_sel    = 1'b1;
                    prod_sel = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                oBusy    = 1'b1;
                shift_en = 1'b1;
                add_sel  = iLSB;
                // count_done flags the final iteration, so DONE follows the WIDTH-th edge
                if (count_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                oDone = 1'b1;
                if (iAck) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/data_path.sv
// Sequential unsigned shift-and-add multiplier: operand/product registers, adder and iteration counter.
module data_path
    import data_path_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
)(
    input  logic        Clock,
    input  logic        Reset,
    data_path_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [2*WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic a_sel, b_sel, prod_sel, add_sel, shift_en, count_done;

    assign count_done = (count_q == CNT_W'(WIDTH - 1));

    control_machine u_ctrl (
        .Clock       (Clock),
        .Reset       (Reset),
        .iValid_Data (bus.iValid_Data),
        .iAck        (bus.iAck),
        .iLSB        (b_q[0]),
        .count_done  (count_done),
        .a_sel       (a_sel),
        .b_sel       (b_sel),
        .prod_sel    (prod_sel),
        .add_sel     (add_sel),
        .shift_en    (shift_en),
        .oDone       (bus.oDone),
        .oBusy       (bus.oBusy)
    );

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        count_d = count_q;
        if (a_sel) begin
            a_d = {{WIDTH{1'b0}}, bus.Data_A};
        end else if (shift_en) begin
            a_d = a_q << 1;
        end
        if (b_sel) begin
            b_d = bus.Data_B;
        end else if (shift_en) begin
            b_d = b_q >> 1;
        end
        // Sum uses the pre-shift multiplicand, matching the bit currently at b_q[0]
        if (prod_sel) begin
            prod_d = '0;
        end else if (add_sel) begin
            prod_d = prod_q + a_q;
        end
        if (prod_sel) begin
            count_d = '0;
        end else if (shift_en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            count_q <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            count_q <= count_d;
        end
    end

    assign bus.Prod   = prod_q;
    assign bus.oB_LSB = b_q[0];

endmodule

// File: tb/tb_data_path.sv
// Randomized scoreboard bench for data_path: driver queues expected products, monitor checks on oDone.
module tb_data_path;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic prev_done = 1'b0;

    typedef struct {
        logic [63:0] prod;
        int          load_cyc;
    } exp_t;

    exp_t sb[$];

    data_path_if #(.WIDTH(32)) dif ();

    data_path #(.WIDTH(32)) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (dif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: a rising oDone is one completed multiplication
    always @(negedge clk) begin
        if (rst_n && dif.oDone && !prev_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(dif.oDone), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_prod", dif.Prod, e.prod);
                check("result_latency", 64'(cyc - e.load_cyc), 64'd32);
                $display("txn: prod=0x%016h load_cyc=%0d done_cyc=%0d", dif.Prod, e.load_cyc, cyc);
            end
        end
        prev_done <= dif.oDone;
    end

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wa;
        logic [63:0] wb;
        wa = {32'd0, a};
        wb = {32'd0, b};
        return wa * wb;
    endfunction

    task automatic wait_idle();
        int t = 0;
        while ((dif.oBusy || dif.oDone) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("idle_timeout", 64'(dif.oBusy | dif.oDone), 64'd0);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int ack_delay, input bit noise);
        logic [63:0] exp;
        int t;
        exp = ref_mul(a, b);
        wait_idle();
        dif.Data_A      = a;
        dif.Data_B      = b;
        dif.iValid_Data = 1'b1;
        dif.iAck        = 1'b0;
        sb.push_back('{prod: exp, load_cyc: cyc + 1});
        @(negedge clk);
        check("busy_after_load", 64'(dif.oBusy), 64'd1);
        check("lsb_after_load", 64'(dif.oB_LSB), 64'(b[0]));
        dif.iValid_Data = 1'b0;
        t = 0;
        while (!dif.oDone && t < 40) begin
            if (noise) begin
                dif.Data_A      = $urandom;
                dif.Data_B      = $urandom;
                dif.iValid_Data = 1'($urandom_range(0, 1));
                dif.iAck        = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            t++;
        end
        check("done_seen", 64'(dif.oDone), 64'd1);
        dif.iAck        = 1'b0;
        dif.iValid_Data = 1'b0;
        for (int i = 0; i < ack_delay; i++) begin
            if (noise) begin
                dif.Data_A      = $urandom;
                dif.iValid_Data = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        check("done_held", 64'(dif.oDone), 64'd1);
        check("prod_frozen", dif.Prod, exp);
        dif.iValid_Data = 1'b0;
        dif.iAck        = 1'b1;
        @(negedge clk);
        dif.iAck = 1'b0;
        check("ack_to_idle", 64'(dif.oDone | dif.oBusy), 64'd0);
        check("prod_retained", dif.Prod, exp);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int l0;
        rst_n           = 1'b0;
        dif.Data_A      = '0;
        dif.Data_B      = '0;
        dif.iValid_Data = 1'b0;
        dif.iAck        = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_prod", dif.Prod, 64'd0);
        check("reset_done", 64'(dif.oDone), 64'd0);
        check("reset_busy", 64'(dif.oBusy), 64'd0);
        check("reset_lsb", 64'(dif.oB_LSB), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'd10, 32'd349525, 3, 1'b0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        do_op(32'd0, 32'h1234_5678, 1, 1'b0);
        do_op(32'd1, 32'h8000_0000, 2, 1'b0);

        // Abort mid-run: partial sum after 10 iterations, then reset discards it
        wait_idle();
        ra = $urandom;
        rb = $urandom;
        dif.Data_A      = ra;
        dif.Data_B      = rb;
        dif.iValid_Data = 1'b1;
        sb.push_back('{prod: ref_mul(ra, rb), load_cyc: cyc + 1});
        @(negedge clk);
        dif.iValid_Data = 1'b0;
        repeat (10) @(negedge clk);
        check("partial_sum_10", dif.Prod, ref_mul(ra, rb & 32'h3FF));
        rst_n = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("abort_prod", dif.Prod, 64'd0);
        check("abort_busy", 64'(dif.oBusy), 64'd0);
        check("abort_done", 64'(dif.oDone), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(32'd3, 32'd5, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            do_op($urandom, $urandom, $urandom_range(0, 4), 1'b1);
        end

        // iValid and iAck both held high: one IDLE edge between each ack and the next load
        wait_idle();
        dif.Data_A      = 32'd7;
        dif.Data_B      = 32'd6;
        dif.iValid_Data = 1'b1;
        dif.iAck        = 1'b1;
        l0 = cyc + 1;
        for (int k = 0; k < 3; k++) sb.push_back('{prod: 64'd42, load_cyc: l0 + 34 * k});
        while (cyc < l0 + 68) @(negedge clk);
        dif.iValid_Data = 1'b0;
        while (cyc < l0 + 101) @(negedge clk);
        dif.iAck = 1'b0;
        check("held_high_idle", 64'(dif.oDone | dif.oBusy), 64'd0);
        check("held_high_prod", dif.Prod, 64'd42);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
